// File: rtl/keypad_serial_rx_pkg.sv
// rtl/keypad_serial_rx_pkg.sv - shared constants and P1 nibble helper for the keypad receiver
package keypad_serial_rx_pkg;

  typedef logic [7:0] key_vec_t;

  localparam int KEY_RIGHT  = 0;
  localparam int KEY_LEFT   = 1;
  localparam int KEY_UP     = 2;
  localparam int KEY_DOWN   = 3;
  localparam int KEY_A      = 4;
  localparam int KEY_B      = 5;
  localparam int KEY_SELECT = 6;
  localparam int KEY_START  = 7;

  localparam logic [15:0] P1_ADDR_DEFAULT = 16'hFF00;
  localparam logic [1:0]  P1_FIXED        = 2'b11;

  // Active-low group select; pressed keys read back as 0.
  function automatic logic [3:0] p1_nib(input logic [1:0] sel, input key_vec_t keys);
    logic [3:0] dir_grp;
    logic [3:0] btn_grp;
    dir_grp = sel[0] ? 4'h0 : keys[KEY_DOWN:KEY_RIGHT];
    btn_grp = sel[1] ? 4'h0 : keys[KEY_START:KEY_A];
    return ~(dir_grp | btn_grp);
  endfunction

endpackage

// File: rtl/keypad_serial_rx_if.sv
// rtl/keypad_serial_rx_if.sv - serial link and CPU bus bundle for the keypad receiver
interface keypad_serial_rx_if;
  logic        hsync;
  logic        pvalid;
  logic        skey;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        wr;
  logic        int_joy;

  modport master (
    output hsync, pvalid, skey, a, din, rd, wr,
    input  dout, int_joy
  );

  modport slave (
    input  hsync, pvalid, skey, a, din, rd, wr,
    output dout, int_joy
  );
endinterface

// File: rtl/keypad_deser.sv
// rtl/keypad_deser.sv - hsync/pvalid framed MSB-first deserializer for the keypad link
module keypad_deser
  import keypad_serial_rx_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     hsync_i,
  input  logic     pvalid_i,
  input  logic     skey_i,
  output key_vec_t cap_data_o,
  output logic     cap_valid_o
);

  logic [3:0] cnt_q, cnt_d;
  key_vec_t   sh_q, sh_d;
  logic       armed_q, armed_d;
  logic       cap_valid_q, cap_valid_d;

  // armed_q blocks capture after reset until a real line start is seen.
  always_comb begin
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    armed_d     = armed_q;
    cap_valid_d = 1'b0;
    if (hsync_i) begin
      cnt_d   = 4'd0;
      sh_d    = '0;
      armed_d = 1'b1;
    end else if (pvalid_i && armed_q && (cnt_q < 4'd8)) begin
      sh_d        = {sh_q[6:0], skey_i};
      cnt_d       = cnt_q + 4'd1;
      cap_valid_d = (cnt_q == 4'd7);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= 4'd0;
      sh_q        <= '0;
      armed_q     <= 1'b0;
      cap_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      armed_q     <= armed_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign cap_data_o  = sh_q;
  assign cap_valid_o = cap_valid_q;

endmodule

// File: rtl/keypad_serial_rx.sv
// rtl/keypad_serial_rx.sv - keypad link receiver with P1 register and joypad interrupt; optional KEYPAD_DEBOUNCE_EN filter
module keypad_serial_rx
  import keypad_serial_rx_pkg::*;
#(
  parameter logic [15:0] P1_ADDR        = P1_ADDR_DEFAULT,
  parameter int          DEBOUNCE_LINES = 2
) (
  input logic               clk,
  input logic               rstn,
  keypad_serial_rx_if.slave bus
);

  key_vec_t   cap_data;
  logic       cap_valid;
  key_vec_t   key_q, key_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] nib, nib_q;
  logic       int_q, int_d;
  logic       p1_hit;

  keypad_deser u_deser (
    .clk        (clk),
    .rstn       (rstn),
    .hsync_i    (bus.hsync),
    .pvalid_i   (bus.pvalid),
    .skey_i     (bus.skey),
    .cap_data_o (cap_data),
    .cap_valid_o(cap_valid)
  );

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int RW = $clog2(DEBOUNCE_LINES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(DEBOUNCE_LINES);

  key_vec_t      cand_q, cand_d;
  logic [RW-1:0] run_q, run_d;

  // run_q==0 only after reset, so the very first capture always starts a run.
  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    key_d  = key_q;
    if (cap_valid) begin
      if ((cap_data == cand_q) && (run_q != '0)) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      end else begin
        cand_d = cap_data;
        run_d  = RW'(1);
      end
      if (run_d >= RUN_MAX) key_d = cap_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cand_q <= '0;
      run_q  <= '0;
    end else begin
      cand_q <= cand_d;
      run_q  <= run_d;
    end
  end
`else
  always_comb begin
    key_d = cap_valid ? cap_data : key_q;
  end
`endif

  assign p1_hit = (bus.a == P1_ADDR);
  assign nib    = p1_nib(sel_q, key_q);

  always_comb begin
    sel_d = (bus.wr && p1_hit) ? bus.din[5:4] : sel_q;
    int_d = |(nib_q & ~nib);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_q <= '0;
      sel_q <= 2'b11;
      nib_q <= 4'hF;
      int_q <= 1'b0;
    end else begin
      key_q <= key_d;
      sel_q <= sel_d;
      nib_q <= nib;
      int_q <= int_d;
    end
  end

  assign bus.dout    = (bus.rd && p1_hit) ? {P1_FIXED, sel_q, nib} : 8'hFF;
  assign bus.int_joy = int_q;

endmodule

// File: tb/tb_keypad_serial_rx.sv
// tb/tb_keypad_serial_rx.sv - scoreboard bench for keypad_serial_rx
module tb_keypad_serial_rx;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  keypad_serial_rx_if bus();

  keypad_serial_rx #(
    .P1_ADDR       (16'hFF00),
    .DEBOUNCE_LINES(2)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_rd_q[$];
  string      rd_name_q[$];
  string      int_name_q[$];
  logic       int_prev = 1'b0;
  logic [7:0] exp_v;
  string      nm;

  // Monitor: pops expected read data on every read strobe, and one token per interrupt pulse.
  always @(negedge clk) begin
    if (bus.rd) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %h want no read", bus.dout);
      end else begin
        exp_v = exp_rd_q.pop_front();
        nm = rd_name_q.pop_front();
        if (bus.dout !== exp_v) begin
          errors++;
          $display("FAIL %s: got %h want %h", nm, bus.dout, exp_v);
        end
      end
    end
    if (bus.int_joy) begin
      checks++;
      if (int_prev) begin
        errors++;
        $display("FAIL int_width: got pulse longer than 1 cycle want 1 cycle");
      end else if (int_name_q.size() == 0) begin
        errors++;
        $display("FAIL int_unexpected: got int_joy=1 want 0");
      end else begin
        nm = int_name_q.pop_front();
      end
    end
    int_prev = bus.int_joy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    bus.pvalid = 1'b1;
    bus.skey   = b;
    tick();
    bus.pvalid = 1'b0;
    bus.skey   = 1'b0;
  endtask

  task automatic line(input logic [7:0] v);
    bus.hsync = 1'b1;
    tick();
    bus.hsync = 1'b0;
    for (int i = 7; i >= 0; i--) bit_in(v[i]);
  endtask

  task automatic wr_p1(input logic [7:0] d);
    bus.wr  = 1'b1;
    bus.a   = 16'hFF00;
    bus.din = d;
    tick();
    bus.wr  = 1'b0;
    bus.a   = 16'h0000;
  endtask

  task automatic rd_addr(input logic [15:0] addr, input logic [7:0] exp, input string name);
    exp_rd_q.push_back(exp);
    rd_name_q.push_back(name);
    bus.rd = 1'b1;
    bus.a  = addr;
    tick();
    bus.rd = 1'b0;
    bus.a  = 16'h0000;
  endtask

  task automatic drain(input string name);
    repeat (4) tick();
    checks++;
    if (int_name_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending interrupts want 0", name, int_name_q.size());
      int_name_q.delete();
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rd_addr(16'hFF00, 8'hFF, "reset_read");
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    bus.hsync = 1'b0; bus.pvalid = 1'b0; bus.skey = 1'b0;
    bus.a = 16'h0000; bus.din = 8'h00; bus.rd = 1'b0; bus.wr = 1'b0;
    repeat (2) tick();
    rd_addr(16'hFF00, 8'hFF, "reset_state");
    rstn = 1'b1;
    tick();

    // Basic capture of 8'h81 with the button group selected.
    wr_p1(8'h10);
    tick();
    int_name_q.push_back("basic_int");
    line(8'h81);
    rd_addr(16'hFF00, 8'hDF, "basic_old_value");
    rd_addr(16'hFF00, 8'hD7, "basic_start");
    for (int i = 0; i < 3; i++) bit_in(1'b1);
    rd_addr(16'hFF00, 8'hD7, "basic_extra_ignored");
    rd_addr(16'hFF01, 8'hFF, "other_addr");
    drain("basic_int_count");
    int_name_q.push_back("dir_int");
    wr_p1(8'h20);
    rd_addr(16'hFF00, 8'hEE, "dir_right");
    drain("dir_int_count");

    // Short line, then a continuation that must not complete the old count.
    do_reset();
    wr_p1(8'h00);
    bus.hsync = 1'b1; tick(); bus.hsync = 1'b0;
    for (int i = 0; i < 5; i++) bit_in(1'b1);
    bus.hsync = 1'b1; tick(); bus.hsync = 1'b0;
    repeat (2) tick();
    rd_addr(16'hFF00, 8'hCF, "short_line");
    for (int i = 0; i < 3; i++) bit_in(1'b1);
    repeat (2) tick();
    rd_addr(16'hFF00, 8'hCF, "short_cleared");
    drain("short_no_int");

    // hsync together with pvalid must not take a bit.
    do_reset();
    wr_p1(8'h20);
    int_name_q.push_back("overlap_int");
    bus.hsync = 1'b1; tick();
    bus.pvalid = 1'b1; bus.skey = 1'b1; tick();
    bus.hsync = 1'b0; bus.pvalid = 1'b0; bus.skey = 1'b0;
    for (int i = 7; i >= 0; i--) bit_in(i == 1);
    repeat (2) tick();
    rd_addr(16'hFF00, 8'hED, "overlap_low");
    wr_p1(8'h10);
    rd_addr(16'hFF00, 8'hDF, "overlap_high");
    drain("overlap_int_count");

    // Reset mid-capture, then unarmed bits, then a full line.
    bus.hsync = 1'b1; tick(); bus.hsync = 1'b0;
    for (int i = 0; i < 4; i++) bit_in(1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) bit_in(1'b1);
    wr_p1(8'h00);
    repeat (2) tick();
    rd_addr(16'hFF00, 8'hCF, "rst_unarmed");
    drain("rst_no_int");
    int_name_q.push_back("rst_line_int");
    line(8'h81);
    repeat (2) tick();
    rd_addr(16'hFF00, 8'hC6, "rst_recapture");
    drain("rst_int_count");

    // Capture sequence 01,00,01,01 on the direction group.
    do_reset();
    wr_p1(8'h20);
`ifdef KEYPAD_DEBOUNCE_EN
    line(8'h01); repeat (2) tick(); rd_addr(16'hFF00, 8'hEF, "seq1");
    line(8'h00); repeat (2) tick(); rd_addr(16'hFF00, 8'hEF, "seq2");
    line(8'h01); repeat (2) tick(); rd_addr(16'hFF00, 8'hEF, "seq3");
    int_name_q.push_back("seq4_int");
    line(8'h01); repeat (2) tick(); rd_addr(16'hFF00, 8'hEE, "seq4");
`else
    int_name_q.push_back("seq1_int");
    line(8'h01); repeat (2) tick(); rd_addr(16'hFF00, 8'hEE, "seq1");
    line(8'h00); repeat (2) tick(); rd_addr(16'hFF00, 8'hEF, "seq2");
    int_name_q.push_back("seq3_int");
    line(8'h01); repeat (2) tick(); rd_addr(16'hFF00, 8'hEE, "seq3");
    line(8'h01); repeat (2) tick(); rd_addr(16'hFF00, 8'hEE, "seq4");
`endif
    drain("seq_int_count");

    checks++;
    if (exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_drain: got %0d unread expectations want 0", exp_rd_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
